// File: rtl/trng_uart_tx.sv
// rtl/trng_uart_tx.sv - TRNG byte FIFO with 8N1 UART serialiser and register port
module trng_uart_tx #(
   parameter int CLK_HZ     = 64000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] byte_in,
   input  logic       byte_strobe,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic [7:0] uo_out
);

   localparam int          DIV      = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
   localparam logic [3:0]  DEPTH    = 4'(FIFO_DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [3:0]    r_count;
   logic          r_enable;
   logic [7:0]    r_drop;
   logic [1:0]    r_state;
   logic [7:0]    r_shift;
   logic [2:0]    r_bitcnt;
   logic [15:0]   r_baud;

   logic w_empty, w_full, w_bit_end;
   logic w_ctrl_wr, w_flush, w_drop_wr;
   logic w_pop, w_push, w_drop;
   logic w_tx, w_busy;
   logic w_unused;

   assign w_empty   = (r_count == 4'd0);
   assign w_full    = (r_count == DEPTH);
   assign w_bit_end = (r_baud == DIV_LAST);
   assign w_ctrl_wr = data_write && (address == 4'd0);
   assign w_flush   = w_ctrl_wr && data_in[1];
   assign w_drop_wr = data_write && (address == 4'd2);

   // Pops happen only when the line is free: from IDLE, or at the last cycle of a STOP bit.
   assign w_pop  = r_enable && !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
   assign w_push = byte_strobe && !w_flush && (!w_full || w_pop);
   assign w_drop = byte_strobe && !w_flush && w_full && !w_pop;
   assign w_unused = &{1'b0, data_in[7:2]};

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= byte_in;
   end

   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= 4'd0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_enable <= 1'b0;
         r_drop   <= 8'd0;
      end else begin
         if (w_ctrl_wr) r_enable <= data_in[0];
         if (w_drop_wr)
            r_drop <= 8'd0;
         else if (w_drop && (r_drop != 8'hFF))
            r_drop <= r_drop + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_baud   <= 16'd0;
         r_bitcnt <= 3'd0;
         r_shift  <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state  <= S_START;
                  r_shift  <= r_mem[r_rptr];
                  r_bitcnt <= 3'd0;
                  r_baud   <= 16'd0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state <= S_DATA;
                  r_baud  <= 16'd0;
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_baud  <= 16'd0;
                  r_shift <= {1'b0, r_shift[7:1]};
                  if (r_bitcnt == 3'd7)
                     r_state <= S_STOP;
                  else
                     r_bitcnt <= r_bitcnt + 3'd1;
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_baud <= 16'd0;
                  if (w_pop) begin
                     r_state  <= S_START;
                     r_shift  <= r_mem[r_rptr];
                     r_bitcnt <= 3'd0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_tx = 1'b1;
      case (r_state)
         S_START: w_tx = 1'b0;
         S_DATA:  w_tx = r_shift[0];
         default: w_tx = 1'b1;
      endcase
   end

   assign w_busy = (r_state != S_IDLE);
   assign uo_out = {6'b0, w_busy, w_tx};

   always_comb begin
      data_out = 8'd0;
      case (address)
         4'd0:    data_out = {7'b0, r_enable};
         4'd1:    data_out = {1'b0, r_count, w_full, w_empty, w_busy};
         4'd2:    data_out = r_drop;
         default: data_out = 8'd0;
      endcase
   end

endmodule

// File: tb/tb_trng_uart_tx.sv
// tb/tb_trng_uart_tx.sv - directed self-checking bench for trng_uart_tx at DIV=4
module tb_trng_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] byte_in = 8'd0;
   logic       byte_strobe = 1'b0;
   logic [3:0] address = 4'd0;
   logic       data_write = 1'b0;
   logic [7:0] data_in = 8'd0;
   logic [7:0] data_out;
   logic [7:0] uo_out;

   int n_total = 0;
   int n_pass  = 0;

   trng_uart_tx #(.CLK_HZ(16), .BAUD(4), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .byte_in     (byte_in),
      .byte_strobe (byte_strobe),
      .address     (address),
      .data_write  (data_write),
      .data_in     (data_in),
      .data_out    (data_out),
      .uo_out      (uo_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
      address = a;
      #1;
      chk(tag, data_out, exp);
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      address    = a;
      data_in    = d;
      data_write = 1'b1;
      tick();
      data_write = 1'b0;
   endtask

   task automatic strobe(input logic [7:0] b);
      byte_in     = b;
      byte_strobe = 1'b1;
      tick();
      byte_strobe = 1'b0;
   endtask

   // Expects the START bit to be on the line now; returns 40 cycles later.
   task automatic frame_chk(input string tag, input logic [7:0] b);
      logic e;
      for (int i = 0; i < 40; i++) begin
         if (i < 4)       e = 1'b0;
         else if (i < 36) e = b[(i - 4) / 4];
         else             e = 1'b1;
         chk(tag, uo_out, {6'b0, 1'b1, e});
         tick();
      end
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      rd_chk("reset_status", 4'd1, 8'h02);
      chk("reset_uo", uo_out, 8'h01);
      rd_chk("reset_ctrl", 4'd0, 8'h00);
      rd_chk("reset_drop", 4'd2, 8'h00);
      rd_chk("reset_unmapped", 4'd7, 8'h00);

      wr(4'd0, 8'h01);
      strobe(8'hA5);
      chk("a5_idle_before_start", uo_out, 8'h01);
      tick();
      frame_chk("frame_a5", 8'hA5);
      chk("a5_idle_after", uo_out, 8'h01);

      wr(4'd0, 8'h00);
      for (int i = 1; i <= 5; i++) strobe(8'(i));
      rd_chk("fill_status", 4'd1, 8'h24);
      rd_chk("fill_drop", 4'd2, 8'h01);
      wr(4'd0, 8'h01);
      tick();
      frame_chk("b2b_01", 8'h01);
      frame_chk("b2b_02", 8'h02);
      frame_chk("b2b_03", 8'h03);
      frame_chk("b2b_04", 8'h04);
      chk("b2b_idle", uo_out, 8'h01);
      rd_chk("b2b_status", 4'd1, 8'h02);

      wr(4'd0, 8'h00);
      for (int i = 0; i < 4; i++) strobe(8'h10 + 8'(i));
      wr(4'd0, 8'h01);
      tick();
      strobe(8'h14);
      rd_chk("full_refill_status", 4'd1, 8'h25);
      repeat (38) tick();
      chk("full_last_stop", uo_out, 8'h03);
      rd_chk("full_last_stop_status", 4'd1, 8'h25);
      strobe(8'h15);
      chk("full_pushpop_start", uo_out, 8'h02);
      rd_chk("full_pushpop_status", 4'd1, 8'h25);
      rd_chk("full_pushpop_drop", 4'd2, 8'h01);
      wr(4'd0, 8'h00);
      repeat (40) tick();
      chk("disable_idle", uo_out, 8'h01);
      rd_chk("disable_status", 4'd1, 8'h24);

      byte_in     = 8'h77;
      byte_strobe = 1'b1;
      repeat (300) tick();
      byte_strobe = 1'b0;
      rd_chk("drop_saturate", 4'd2, 8'hFF);
      address     = 4'd2;
      data_write  = 1'b1;
      byte_strobe = 1'b1;
      tick();
      data_write  = 1'b0;
      byte_strobe = 1'b0;
      rd_chk("drop_clear_wins", 4'd2, 8'h00);
      rd_chk("drop_fifo_intact", 4'd1, 8'h24);

      wr(4'd0, 8'h01);
      tick();
      chk("flush_frame_start", uo_out, 8'h02);
      repeat (10) tick();
      wr(4'd0, 8'h03);
      rd_chk("flush_status", 4'd1, 8'h03);
      rd_chk("flush_ctrl_read", 4'd0, 8'h01);
      repeat (29) tick();
      chk("flush_frame_done", uo_out, 8'h01);
      rd_chk("flush_end_status", 4'd1, 8'h02);
      repeat (8) tick();
      chk("flush_no_more", uo_out, 8'h01);

      wr(4'd0, 8'h00);
      for (int i = 0; i < 4; i++) strobe(8'h20 + 8'(i));
      wr(4'd0, 8'h01);
      tick();
      strobe(8'h24);
      rd_chk("flush2_full", 4'd1, 8'h25);
      repeat (9) tick();
      address     = 4'd0;
      data_in     = 8'h03;
      data_write  = 1'b1;
      byte_in     = 8'h99;
      byte_strobe = 1'b1;
      tick();
      data_write  = 1'b0;
      byte_strobe = 1'b0;
      rd_chk("flush2_status", 4'd1, 8'h03);
      rd_chk("flush2_drop", 4'd2, 8'h00);
      repeat (29) tick();
      chk("flush2_frame_done", uo_out, 8'h01);
      rd_chk("flush2_end_status", 4'd1, 8'h02);

      wr(4'd0, 8'h00);
      for (int i = 0; i < 5; i++) strobe(8'h30 + 8'(i));
      rd_chk("rst_pre_drop", 4'd2, 8'h01);
      wr(4'd0, 8'h01);
      tick();
      repeat (17) tick();
      chk("rst_in_bit3", uo_out, 8'h02);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_uo", uo_out, 8'h01);
      rd_chk("rst_status", 4'd1, 8'h02);
      rd_chk("rst_ctrl", 4'd0, 8'h00);
      rd_chk("rst_drop", 4'd2, 8'h00);
      repeat (10) tick();
      chk("rst_stays_idle", uo_out, 8'h01);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
